// File: rtl/hog_scan_counter.sv
// Two-dimensional scan index generator: a prescaler paces column steps, column
// wraps advance the row, and the last position closes the frame.
module hog_scan_counter #(
    parameter int PRESCALE = 53,
    parameter int COLS     = 106,
    parameter int ROWS     = 1,
    parameter int PRE_W    = 6,
    parameter int COL_W    = 7,
    parameter int ROW_W    = 7
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic             iEn,
    input  logic             iContinuous,
    output logic [COL_W-1:0] oCol,
    output logic [ROW_W-1:0] oRow,
    output logic             oStep,
    output logic             oRowEnd,
    output logic             oFrameDone,
    output logic             oBusy
);

    // Terminal counts fit their registers because each parameter is at most 2^width.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst || iAbort) begin
            state      <= IDLE;
            pre        <= '0;
            oCol       <= '0;
            oRow       <= '0;
            oStep      <= 1'b0;
            oRowEnd    <= 1'b0;
            oFrameDone <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly the cycle it is set.
            oStep      <= 1'b0;
            oRowEnd    <= 1'b0;
            oFrameDone <= 1'b0;
            case (state)
                IDLE: begin
                    pre  <= '0;
                    oCol <= '0;
                    oRow <= '0;
                    if (iStart) begin
                        state <= RUN;
                        oBusy <= 1'b1;
                    end
                end
                RUN: begin
                    if (iEn) begin
                        if (pre == PRE_LAST) begin
                            pre   <= '0;
                            oStep <= 1'b1;
                            if (oCol != COL_LAST) begin
                                oCol <= oCol + 1'b1;
                            end else begin
                                oCol    <= '0;
                                oRowEnd <= 1'b1;
                                if (oRow != ROW_LAST) begin
                                    oRow <= oRow + 1'b1;
                                end else begin
                                    // Frame end: iContinuous is only looked at here.
                                    oRow       <= '0;
                                    oFrameDone <= 1'b1;
                                    if (!iContinuous) begin
                                        state <= IDLE;
                                        oBusy <= 1'b0;
                                    end
                                end
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hog_scan_counter.sv
// Directed bench for hog_scan_counter: three instances cover the small 3/4/2
// geometry, the default 53/106/1 geometry and the degenerate 1/1/1 geometry.
module tb_hog_scan_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: PRESCALE=3, COLS=4, ROWS=2
    logic       a_rst = 1'b1, a_start = 1'b0, a_abort = 1'b0, a_en = 1'b1, a_cont = 1'b0;
    logic [6:0] a_col, a_row;
    logic       a_step, a_rowend, a_done, a_busy;

    // Instance B: default parameters
    logic       b_rst = 1'b1, b_start = 1'b0, b_abort = 1'b0, b_en = 1'b1, b_cont = 1'b0;
    logic [6:0] b_col, b_row;
    logic       b_step, b_rowend, b_done, b_busy;

    // Instance C: PRESCALE=1, COLS=1, ROWS=1
    logic       c_rst = 1'b1, c_start = 1'b0, c_abort = 1'b0, c_en = 1'b1, c_cont = 1'b0;
    logic [6:0] c_col, c_row;
    logic       c_step, c_rowend, c_done, c_busy;

    hog_scan_counter #(.PRESCALE(3), .COLS(4), .ROWS(2)) u_a (
        .iClk(clk), .iRst(a_rst), .iStart(a_start), .iAbort(a_abort), .iEn(a_en),
        .iContinuous(a_cont), .oCol(a_col), .oRow(a_row), .oStep(a_step),
        .oRowEnd(a_rowend), .oFrameDone(a_done), .oBusy(a_busy)
    );

    hog_scan_counter u_b (
        .iClk(clk), .iRst(b_rst), .iStart(b_start), .iAbort(b_abort), .iEn(b_en),
        .iContinuous(b_cont), .oCol(b_col), .oRow(b_row), .oStep(b_step),
        .oRowEnd(b_rowend), .oFrameDone(b_done), .oBusy(b_busy)
    );

    hog_scan_counter #(.PRESCALE(1), .COLS(1), .ROWS(1)) u_c (
        .iClk(clk), .iRst(c_rst), .iStart(c_start), .iAbort(c_abort), .iEn(c_en),
        .iContinuous(c_cont), .oCol(c_col), .oRow(c_row), .oStep(c_step),
        .oRowEnd(c_rowend), .oFrameDone(c_done), .oBusy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int col, input int row, input int step,
                         input int rowend, input int done, input int busy);
        chk({tag, ".a_col"},    32'(a_col),    col);
        chk({tag, ".a_row"},    32'(a_row),    row);
        chk({tag, ".a_step"},   32'(a_step),   step);
        chk({tag, ".a_rowend"}, 32'(a_rowend), rowend);
        chk({tag, ".a_done"},   32'(a_done),   done);
        chk({tag, ".a_busy"},   32'(a_busy),   busy);
    endtask

    task automatic chk_b(input string tag, input int col, input int row, input int step,
                         input int rowend, input int done, input int busy);
        chk({tag, ".b_col"},    32'(b_col),    col);
        chk({tag, ".b_row"},    32'(b_row),    row);
        chk({tag, ".b_step"},   32'(b_step),   step);
        chk({tag, ".b_rowend"}, 32'(b_rowend), rowend);
        chk({tag, ".b_done"},   32'(b_done),   done);
        chk({tag, ".b_busy"},   32'(b_busy),   busy);
    endtask

    task automatic chk_c(input string tag, input int col, input int row, input int step,
                         input int rowend, input int done, input int busy);
        chk({tag, ".c_col"},    32'(c_col),    col);
        chk({tag, ".c_row"},    32'(c_row),    row);
        chk({tag, ".c_step"},   32'(c_step),   step);
        chk({tag, ".c_rowend"}, 32'(c_rowend), rowend);
        chk({tag, ".c_done"},   32'(c_done),   done);
        chk({tag, ".c_busy"},   32'(c_busy),   busy);
    endtask

    initial begin
        int n;

        // Reset state, with start/abort-free inputs
        tick();
        chk_a("reset", 0, 0, 0, 0, 0, 0);
        chk_b("reset", 0, 0, 0, 0, 0, 0);
        chk_c("reset", 0, 0, 0, 0, 0, 0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        tick();

        // A: single-shot frame, iStart sampled at edge 0
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a("ss_e0", 0, 0, 0, 0, 0, 1);
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk_a($sformatf("ss_e%0d", e),
                  (e < 24) ? (e / 3) % 4 : 0,
                  (e < 24) ? (e / 3) / 4 : 0,
                  (e % 3 == 0 && e <= 24) ? 1 : 0,
                  (e == 12 || e == 24) ? 1 : 0,
                  (e == 24) ? 1 : 0,
                  (e < 24) ? 1 : 0);
        end

        // A: reset mid-frame at position (2,1) with the prescaler at 1
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (19) tick();
        chk_a("pre_rst", 2, 1, 0, 0, 0, 1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk_a("rst_mid", 0, 0, 0, 0, 0, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a("restart_e0", 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk_a("restart_e2", 0, 0, 0, 0, 0, 1);
        tick();
        chk_a("restart_e3", 1, 0, 1, 0, 0, 1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk_a("restart_abort", 0, 0, 0, 0, 0, 0);

        // A: continuous mode with a stray iStart pulse mid-frame
        a_cont  = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int e = 1; e <= 75; e++) begin
            tick();
            a_start = (e == 30);
            chk_a($sformatf("cont_e%0d", e),
                  (e / 3) % 4,
                  ((e / 3) / 4) % 2,
                  (e % 3 == 0) ? 1 : 0,
                  (e % 12 == 0) ? 1 : 0,
                  (e % 24 == 0) ? 1 : 0,
                  1);
        end
        a_start = 1'b0;
        a_cont  = 1'b0;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk_a("cont_abort", 0, 0, 0, 0, 0, 0);

        // A: abort beats start in IDLE, then abort during RUN at (3,0)
        a_abort = 1'b1;
        a_start = 1'b1;
        tick();
        a_abort = 1'b0;
        a_start = 1'b0;
        chk_a("abort_idle", 0, 0, 0, 0, 0, 0);
        tick();
        chk_a("abort_idle_hold", 0, 0, 0, 0, 0, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (9) tick();
        chk_a("pre_abort", 3, 0, 1, 0, 0, 1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk_a("abort_run", 0, 0, 0, 0, 0, 0);
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk_a($sformatf("post_abort_e%0d", e), 0, 0, 0, 0, 0, 0);
        end

        // B: default geometry, iEn low for edges 21..30 with the prescaler at 20
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk_b("stall_e0", 0, 0, 0, 0, 0, 1);
        for (int e = 1; e <= 5635; e++) begin
            tick();
            n = (e <= 20) ? e : ((e <= 30) ? 20 : e - 10);
            chk_b($sformatf("stall_e%0d", e),
                  (n < 5618) ? (n / 53) % 106 : 0,
                  0,
                  (n % 53 == 0 && n <= 5618) ? 1 : 0,
                  (n == 5618) ? 1 : 0,
                  (n == 5618) ? 1 : 0,
                  (n < 5618) ? 1 : 0);
            b_en = !(e >= 20 && e < 30);
        end

        // C: degenerate 1/1/1 geometry in continuous mode
        c_cont  = 1'b1;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        chk_c("deg_e0", 0, 0, 0, 0, 0, 1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_c($sformatf("deg_e%0d", e), 0, 0, 1, 1, 1, 1);
        end
        c_en = 1'b0;
        tick();
        chk_c("deg_stall", 0, 0, 0, 0, 0, 1);
        c_en = 1'b1;
        tick();
        chk_c("deg_resume", 0, 0, 1, 1, 1, 1);
        c_cont = 1'b0;
        tick();
        chk_c("deg_last", 0, 0, 1, 1, 1, 0);
        tick();
        chk_c("deg_idle", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
